beta_loader: RTL and testbench

// Program-image writer for Beta main memory: drives the memory write port while holding the CPU in reset.

---
 rtl/beta_loader_pkg.sv | 23 ++
 rtl/beta_byte_shifter.sv | 27 ++
 rtl/beta_loader.sv | 117 +++++++++++
 tb/tb_beta_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/beta_loader_pkg.sv
// Shared types and field lengths for the Beta program-image loader.
package beta_loader_pkg;

  typedef enum logic [2:0] {
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int ADDR_BYTES  = 4;
  localparam int COUNT_BYTES = 2;
  localparam int WORD_BYTES  = 4;

  // Byte-counter value seen while the final byte of an n-byte field transfers.
  function automatic logic [1:0] lastIdx(input int n);
    return 2'(n - 1);
  endfunction

endpackage

// File: rtl/beta_byte_shifter.sv
// Big-endian field assembler shared by the ADDR, COUNT and DATA fields of the loader.
// The newest byte is taken straight from the input so a finished field is usable on its final transfer.
module beta_byte_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] fieldValue,
  output logic [1:0]  byteCnt
);

  logic [23:0] held;

  assign fieldValue = {held, byteIn};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      held    <= '0;
      byteCnt <= '0;
    end else if (shiftEn) begin
      held    <= {held[15:0], byteIn};
      byteCnt <= byteCnt + 2'd1;
    end
  end

endmodule

// File: rtl/beta_loader.sv
// Writes a framed byte stream (ADDR, COUNT, DATA words, XOR checksum) into Beta main memory
// while holding the CPU in reset; releases the CPU only after a good checksum.
import beta_loader_pkg::*;

module beta_loader #(
  parameter int MAX_WORDS = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  state_t      state, stateNext;
  logic [31:0] addrQ;
  logic [15:0] cntQ;
  logic [7:0]  csum;
  logic        xfer, shiftEn, fieldLast;
  logic [31:0] fieldValue;
  logic [1:0]  byteCnt;

  assign xfer = rx_valid & rx_ready;

  beta_byte_shifter uShifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (shiftEn & fieldLast),
    .shiftEn   (shiftEn),
    .byteIn    (rx_data),
    .fieldValue(fieldValue),
    .byteCnt   (byteCnt)
  );

  always_comb begin
    stateNext = state;
    rx_ready  = 1'b0;
    shiftEn   = 1'b0;
    fieldLast = 1'b0;
    unique case (state)
      S_ADDR: begin
        rx_ready  = 1'b1;
        shiftEn   = xfer;
        fieldLast = (byteCnt == lastIdx(ADDR_BYTES));
        if (xfer && fieldLast) stateNext = S_COUNT;
      end
      S_COUNT: begin
        rx_ready  = 1'b1;
        shiftEn   = xfer;
        fieldLast = (byteCnt == lastIdx(COUNT_BYTES));
        if (xfer && fieldLast) begin
          if ({16'h0, fieldValue[15:0]} > MaxWords) stateNext = S_ERR;
          else if (fieldValue[15:0] == 16'h0)       stateNext = S_CSUM;
          else                                      stateNext = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready  = 1'b1;
        shiftEn   = xfer;
        fieldLast = (byteCnt == lastIdx(WORD_BYTES));
        if (xfer && fieldLast) stateNext = S_WRITE;
      end
      S_WRITE: stateNext = (cntQ == 16'd1) ? S_CSUM : S_DATA;
      S_CSUM: begin
        rx_ready = 1'b1;
        if (xfer) stateNext = (rx_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE:  stateNext = S_DONE;
      S_ERR:   stateNext = S_ERR;
      default: stateNext = S_ERR;
    endcase
  end

  assign mem_we  = (state == S_WRITE);
  assign cpu_rst = (state != S_DONE);
  assign done    = (state == S_DONE);
  assign error   = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ADDR;
      addrQ     <= '0;
      cntQ      <= '0;
      csum      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= stateNext;
      if (xfer && state != S_CSUM) csum <= csum ^ rx_data;
      if (shiftEn && fieldLast) begin
        unique case (state)
          S_ADDR:  addrQ <= {fieldValue[31:2], 2'b00};
          S_COUNT: cntQ  <= fieldValue[15:0];
          S_DATA: begin
            mem_addr  <= addrQ;
            mem_wdata <= fieldValue;
          end
          default: ;
        endcase
      end
      // Address wraps silently past 0xFFFFFFFC.
      if (state == S_WRITE) begin
        addrQ <= addrQ + 32'd4;
        cntQ  <= cntQ - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_beta_loader.sv
// Directed frame-level bench for beta_loader; a second instance uses MAX_WORDS=0.
module tb_beta_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxReady, memWe, cpuRst, done, error;
  logic [31:0] memAddr, memWdata;
  logic        rxReady0, memWe0, cpuRst0, done0, error0;
  logic [31:0] memAddr0, memWdata0;

  int nCmp = 0;
  int nBad = 0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  typedef struct {
    logic [31:0] addr;
    logic [15:0] cnt;
    logic [31:0] w0, w1;
    logic [7:0]  csumXor;
    bit          gaps;
    bit          expDone, expErr;
    int          expN;
    logic [31:0] expA0, expA1;
  } vec_t;

  vec_t vecs[5];

  beta_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rxValid), .rx_data(rxData), .rx_ready(rxReady),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_we(memWe),
    .cpu_rst(cpuRst), .done(done), .error(error)
  );

  beta_loader #(.MAX_WORDS(0)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rxValid), .rx_data(rxData), .rx_ready(rxReady0),
    .mem_addr(memAddr0), .mem_wdata(memWdata0), .mem_we(memWe0),
    .cpu_rst(cpuRst0), .done(done0), .error(error0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWe === 1'b1) begin
      wrAddrQ.push_back(memAddr);
      wrDataQ.push_back(memWdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    rxValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  // Entered and left on a falling edge; the transfer happens on the rising edge in between.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCnt;
    for (int i = 0; i < gap; i++) begin
      rxValid = 1'b0;
      rxData  = 8'($urandom);
      @(negedge clk);
    end
    rxValid = 1'b1;
    rxData  = b;
    waitCnt = 0;
    while (rxReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (rxReady !== 1'b1) begin
      nCmp++;
      nBad++;
      $display("FAIL stall_timeout: rx_ready %b after %0d cycles, expected 1", rxReady, waitCnt);
    end
    @(negedge clk);
  endtask

  task automatic runFrame(input vec_t v);
    logic [7:0]  b[$];
    logic [7:0]  cs;
    logic [31:0] w;
    int          k;
    b = {v.addr[31:24], v.addr[23:16], v.addr[15:8], v.addr[7:0], v.cnt[15:8], v.cnt[7:0]};
    for (int j = 0; j < int'(v.cnt); j++) begin
      w = (j == 0) ? v.w0 : v.w1;
      b.push_back(w[31:24]);
      b.push_back(w[23:16]);
      b.push_back(w[15:8]);
      b.push_back(w[7:0]);
    end
    cs = 8'h00;
    foreach (b[j]) cs = cs ^ b[j];
    b.push_back(cs ^ v.csumXor);
    for (int i = 0; i < b.size(); i++) begin
      sendByte(b[i], v.gaps ? int'($urandom_range(0, 3)) : 0);
      if (i == 4) chk("max0_before_count", error0, 1'b0);
      if (i == 5) chk("max0_after_count", error0, (v.cnt != 16'h0));
      if (i >= 6 && i < b.size() - 1 && (i - 6) % 4 == 3) begin
        k = (i - 6) / 4;
        chk("we_latency", memWe, 1'b1);
        chk("wr_addr", memAddr, (k == 0) ? v.expA0 : v.expA1);
        chk("wr_data", memWdata, (k == 0) ? v.w0 : v.w1);
      end
      if (i == b.size() - 2) chk("cpu_rst_held", cpuRst, 1'b1);
    end
    rxValid = 1'b0;
    chk("done", done, v.expDone);
    chk("error", error, v.expErr);
    chk("cpu_rst_after", cpuRst, !v.expDone);
    chk("rx_ready_after", rxReady, 1'b0);
    chk("we_idle", memWe, 1'b0);
    chk("n_writes", wrAddrQ.size(), v.expN);
    for (int j = 0; j < wrAddrQ.size() && j < 2; j++) begin
      chk("q_addr", wrAddrQ[j], (j == 0) ? v.expA0 : v.expA1);
      chk("q_data", wrDataQ[j], (j == 0) ? v.w0 : v.w1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0100, 16'd2, 32'hDEAD_BEEF, 32'h0000_002A, 8'h00, 1'b0,
                1'b1, 1'b0, 2, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0100, 16'd2, 32'hDEAD_BEEF, 32'h0000_002A, 8'h01, 1'b0,
                1'b0, 1'b1, 2, 32'h0000_0100, 32'h0000_0104};
    vecs[2] = '{32'h0000_0100, 16'd0, 32'h0, 32'h0, 8'h00, 1'b0,
                1'b1, 1'b0, 0, 32'h0, 32'h0};
    vecs[3] = '{32'hFFFF_FFFE, 16'd2, 32'h1122_3344, 32'h5566_7788, 8'h00, 1'b0,
                1'b1, 1'b0, 2, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[4] = '{32'h0000_0100, 16'd2, 32'hDEAD_BEEF, 32'h0000_002A, 8'h00, 1'b1,
                1'b1, 1'b0, 2, 32'h0000_0100, 32'h0000_0104};

    rst = 1'b1;
    rxValid = 1'b0;
    rxData = 8'h00;
    @(negedge clk);
    doReset();
    chk("rst_rx_ready", rxReady, 1'b1);
    chk("rst_mem_we", memWe, 1'b0);
    chk("rst_mem_addr", memAddr, 32'h0);
    chk("rst_mem_wdata", memWdata, 32'h0);
    chk("rst_cpu_rst", cpuRst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);

    foreach (vecs[n]) begin
      doReset();
      chk("rerst_cpu_rst", cpuRst, 1'b1);
      chk("rerst_done", done, 1'b0);
      chk("rerst_mem_addr", memAddr, 32'h0);
      runFrame(vecs[n]);
    end

    // MAX_WORDS=0 instance rejects any nonzero count and never writes.
    doReset();
    runFrame('{32'h0000_1000, 16'd1, 32'h1234_5678, 32'h0, 8'h00, 1'b0,
               1'b1, 1'b0, 1, 32'h0000_1000, 32'h0});
    chk("max0_error", error0, 1'b1);
    chk("max0_done", done0, 1'b0);
    chk("max0_cpu_rst", cpuRst0, 1'b1);
    chk("max0_rx_ready", rxReady0, 1'b0);
    chk("max0_mem_we", memWe0, 1'b0);
    chk("max0_mem_addr", memAddr0, 32'h0);
    chk("max0_mem_wdata", memWdata0, 32'h0);

    // Reset after the third data byte discards the partial word.
    doReset();
    sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h02, 0); sendByte(8'h00, 0);
    sendByte(8'h00, 0); sendByte(8'h01, 0);
    sendByte(8'hAA, 0); sendByte(8'hBB, 0); sendByte(8'hCC, 0);
    rxValid = 1'b0;
    chk("mid_cpu_rst_pre", cpuRst, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rx_ready", rxReady, 1'b1);
    chk("mid_cpu_rst", cpuRst, 1'b1);
    chk("mid_mem_we", memWe, 1'b0);
    chk("mid_no_write", wrAddrQ.size(), 0);
    runFrame(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
